unary_accum_multi: RTL

UNARY_ACCUM_MULTI -- requirements
Module: unary_accum_multi

---
 rtl/unary_pkg.sv | 16 +
 rtl/unary_popcount.sv | 22 ++
 rtl/unary_accum_multi.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary accumulator.
//   state_t  : controller state encoding (ACC / DRAIN / DONE)
//   pc_width : bit width needed to hold a popcount of n_lanes lanes
package unary_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int pc_width(input int n_lanes);
        return $clog2(n_lanes + 1);
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// Purely combinational lane counter: number of set bits in din.
//   din : N_IN unary lanes
//   cnt : popcount, pc_width(N_IN) bits
module unary_popcount
    import unary_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0]           din,
    output logic [pc_width(N_IN)-1:0] cnt
);

    localparam int PW = pc_width(N_IN);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + PW'(din[i]);
        end
    end

endmodule

// File: rtl/unary_accum_multi.sv
// Multi-lane unary accumulator with serial unary drain.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : cycle enable; when low every register holds
//   mode       : 0 = accumulate, 1 = request drain
//   clr        : synchronous clear (qualified by en)
//   din        : N_IN unary lanes, popcount added each ACC cycle
//   dout       : serial unary output, one 1 per count unit
//   C          : one-cycle overflow pulse (registered)
//   ovf        : sticky overflow flag
//   done       : one-cycle pulse when the drain reaches zero
//   count_o    : registered accumulator value
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_ACC   | adding popcount(din) each enabled cycle
// ST_DRAIN | emitting one dout 1 per unit, count down to zero
// ST_DONE  | drain finished, waiting for mode=0 to resume ACC
module unary_accum_multi
    import unary_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int CNT_W  = 16,
    parameter int SAT_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    input  logic [N_IN-1:0]  din,
    output logic             dout,
    output logic             C,
    output logic             ovf,
    output logic             done,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = pc_width(N_IN);
    localparam int SW = CNT_W + PW;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             dout_nxt;
    logic             c_nxt;
    logic             ovf_nxt;
    logic             done_nxt;

    logic [PW-1:0]    pc;
    logic [SW-1:0]    sum;
    logic             sum_ovf;
    logic [CNT_W-1:0] acc_val;
    logic             count_zero;

    unary_popcount #(.N_IN(N_IN)) u_popcount (
        .din (din),
        .cnt (pc)
    );

    // Full-width sum so the carry out of CNT_W bits is visible as overflow.
    assign sum        = {{PW{1'b0}}, count} + {{CNT_W{1'b0}}, pc};
    assign sum_ovf    = |sum[SW-1:CNT_W];
    assign acc_val    = ((SAT_EN != 0) && sum_ovf) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign count_zero = (count == '0);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            count <= '0;
            dout  <= 1'b0;
            C     <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            dout  <= dout_nxt;
            C     <= c_nxt;
            ovf   <= ovf_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (en) begin
            if (clr) begin
                state_nxt = ST_ACC;
            end else begin
                case (state)
                    ST_ACC:   if (mode)       state_nxt = ST_DRAIN;
                    ST_DRAIN: if (count_zero) state_nxt = ST_DONE;
                    ST_DONE:  if (!mode)      state_nxt = ST_ACC;
                    default:                  state_nxt = ST_ACC;
                endcase
            end
        end
    end

    // Output / datapath next values. With en low everything holds, which
    // also stretches a dout 1 across disabled cycles during a drain.
    always_comb begin
        count_nxt = count;
        dout_nxt  = dout;
        c_nxt     = C;
        ovf_nxt   = ovf;
        done_nxt  = done;
        if (en) begin
            dout_nxt = 1'b0;
            c_nxt    = 1'b0;
            done_nxt = 1'b0;
            if (clr) begin
                count_nxt = '0;
                ovf_nxt   = 1'b0;
            end else begin
                case (state)
                    ST_ACC: begin
                        if (!mode) begin
                            count_nxt = acc_val;
                            c_nxt     = sum_ovf;
                            ovf_nxt   = ovf | sum_ovf;
                        end
                    end
                    ST_DRAIN: begin
                        if (count_zero) begin
                            done_nxt = 1'b1;
                        end else begin
                            dout_nxt  = 1'b1;
                            count_nxt = count - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign count_o = count;

endmodule
